ram_bus_master: RTL and testbench

//  Initiator side of the RAMControl bus: turns burst commands (base addr, length, dir) from ANN

---
 rtl/ram_bus_pkg.sv | 32 +++
 rtl/ram_timeout_cnt.sv | 27 ++
 rtl/ram_bus_master.sv | 137 +++++++++++++
 tb/tb_ram_bus_master.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bus_pkg.sv
// Shared constants, FSM state codes and request record for the RAMControl bus initiator.
package ram_bus_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;

  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;

  localparam logic [3:0] ST_RECOVER = 4'd0;
  localparam logic [3:0] ST_IDLE    = 4'd1;
  localparam logic [3:0] ST_FETCH   = 4'd2;
  localparam logic [3:0] ST_ISSUE   = 4'd3;
  localparam logic [3:0] ST_SETTLE  = 4'd4;
  localparam logic [3:0] ST_WAIT    = 4'd5;
  localparam logic [3:0] ST_DELIVER = 4'd6;
  localparam logic [3:0] ST_NEXT    = 4'd7;
  localparam logic [3:0] ST_DONE    = 4'd8;

  // Everything the controller sees for one access; held unchanged from latch until Ready.
  typedef struct packed {
    logic              instr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;

  // Word addresses wrap modulo 2^ADDR_W so a burst runs straight across the top of memory.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/ram_timeout_cnt.sv
// Up-counter with synchronous clear; expire is high in the enabled cycle that completes `limit` counts.
module ram_timeout_cnt #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign expire = en && !load && (count == limit - W'(1));

endmodule

// File: rtl/ram_bus_master.sv
// Burst-to-single-word initiator for the RAMControl bus, one access outstanding at a time.
// Read words wait in DELIVER for rd_ready and write words are pulled in FETCH, so either side stalls the next latch.
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int LEN_W       = 16,
  parameter int TIMEOUT     = 64,
  parameter int RECOVER_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_instruction,
  output logic              ram_latch,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready
);

  localparam int CNT_MAX = (TIMEOUT > RECOVER_CYC) ? TIMEOUT : RECOVER_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [3:0]        state;
  ram_req_t          req;
  logic [LEN_W-1:0]  remain;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_expire;
  logic [CNT_W-1:0]  cnt_limit;

  // One counter serves both the post-reset quiet period and the Ready watchdog.
  assign cnt_load  = (state == ST_SETTLE);
  assign cnt_en    = (state == ST_RECOVER) || (state == ST_WAIT);
  assign cnt_limit = (state == ST_RECOVER) ? CNT_W'(RECOVER_CYC) : CNT_W'(TIMEOUT);

  ram_timeout_cnt #(
    .W(CNT_W)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .en     (cnt_en),
    .limit  (cnt_limit),
    .expire (cnt_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RECOVER;
      req     <= '0;
      remain  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_RECOVER: begin
          if (cnt_expire) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (cmd_valid) begin
            req.instr <= cmd_write;
            req.addr  <= cmd_addr;
            remain    <= cmd_len;
            err_q     <= 1'b0;
            if (cmd_len == '0)             state <= ST_DONE;
            else if (cmd_write == RAM_WRITE) state <= ST_FETCH;
            else                           state <= ST_ISSUE;
          end
        end
        ST_FETCH: begin
          if (wr_valid) begin
            req.wdata <= wr_data;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE:  state <= ST_SETTLE;
        // Ready from the previous access may still be high here, so it is not looked at yet.
        ST_SETTLE: state <= ST_WAIT;
        ST_WAIT: begin
          if (ram_ready) begin
            if (req.instr == RAM_READ) begin
              rdata_q <= ram_rdata;
              state   <= ST_DELIVER;
            end else begin
              state <= ST_NEXT;
            end
          end else if (cnt_expire) begin
            err_q <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DELIVER: begin
          if (rd_ready) state <= ST_NEXT;
        end
        ST_NEXT: begin
          remain   <= remain - LEN_W'(1);
          req.addr <= next_addr(req.addr);
          if (remain == LEN_W'(1))          state <= ST_DONE;
          else if (req.instr == RAM_WRITE) state <= ST_FETCH;
          else                             state <= ST_ISSUE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_RECOVER;
      endcase
    end
  end

  assign cmd_ready       = (state == ST_IDLE);
  assign wr_ready        = (state == ST_FETCH);
  assign rd_valid        = (state == ST_DELIVER);
  assign ram_latch       = (state == ST_ISSUE);
  assign done            = (state == ST_DONE);
  assign busy            = (state != ST_IDLE);
  assign err             = err_q;
  assign rd_data         = rdata_q;
  assign ram_addr        = req.addr;
  assign ram_instruction = req.instr;
  assign ram_wdata       = req.wdata;

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: behavioural RAM controller plus an address-arithmetic reference memory.
module tb_ram_bus_master;
  localparam int LEN_W       = 16;
  localparam int TIMEOUT     = 64;
  localparam int RECOVER_CYC = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_write = 1'b0;
  logic [22:0]      cmd_addr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [15:0]      wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [15:0]      rd_data;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic             busy, done, err;
  logic             ram_instruction, ram_latch;
  logic [22:0]      ram_addr;
  logic [15:0]      ram_wdata;
  logic [15:0]      ram_rdata = '0;
  logic             ram_ready = 1'b1;

  int tests = 0;
  int fails = 0;

  ram_bus_master #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .RECOVER_CYC(RECOVER_CYC)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .err(err),
    .ram_instruction(ram_instruction), .ram_latch(ram_latch),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] init_val(input logic [22:0] a);
    return a[15:0] ^ {a[22:16], 9'h15A};
  endfunction

  // Controller model: Ready drops at the latching edge and rises five edges later with the result.
  logic [15:0] cmem [int];
  logic [22:0] latch_q [$];
  logic        latch_w_q [$];
  logic [15:0] rd_q [$];
  int          done_cnt = 0;
  int          overlap_cnt = 0;
  int          stab_err = 0;
  bit          hang = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_abandon = 1'b0;
  int          m_cnt = 0;
  logic [22:0] m_addr = '0;
  logic        m_instr = 1'b0;
  logic [15:0] m_wd = '0;

  always @(posedge clk) begin
    if (ram_latch) begin
      if (m_busy) overlap_cnt++;
      latch_q.push_back(ram_addr);
      latch_w_q.push_back(ram_instruction);
      m_busy    = !hang;
      m_cnt     = 0;
      m_abandon = 1'b0;
      m_addr    = ram_addr;
      m_instr   = ram_instruction;
      m_wd      = ram_wdata;
      ram_ready <= 1'b0;
    end else if (m_busy) begin
      m_cnt++;
      if (rst) m_abandon = 1'b1;
      else if (!m_abandon && (ram_addr !== m_addr || ram_instruction !== m_instr ||
                              (m_instr && ram_wdata !== m_wd))) stab_err++;
      if (m_cnt == 5) begin
        if (m_instr) cmem[int'(m_addr)] = m_wd;
        else ram_rdata <= cmem.exists(int'(m_addr)) ? cmem[int'(m_addr)] : init_val(m_addr);
        ram_ready <= 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rd_valid && rd_ready) rd_q.push_back(rd_data);
    if (done) done_cnt++;
  end

  // Reference memory: what every word should hold, updated by plain address arithmetic.
  logic [15:0] ref_mem [int];
  logic [15:0] wdat [$];
  int lb, rb, db;

  function automatic logic [15:0] ref_rd(input logic [22:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic logic [15:0] cmem_rd(input logic [22:0] a);
    return cmem.exists(int'(a)) ? cmem[int'(a)] : init_val(a);
  endfunction

  task automatic ref_write(input logic [22:0] a, input int n);
    logic [22:0] ea;
    for (int i = 0; i < n; i++) begin
      ea = a + 23'(i);
      ref_mem[int'(ea)] = wdat[i];
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    lb = latch_q.size();
    rb = rd_q.size();
    db = done_cnt;
  endtask

  // Offer one command and service the data stream until done is seen; cyc counts cycles after acceptance.
  task automatic run_burst(input bit wr, input logic [22:0] a, input int n, input int stall_word,
                           input int stall_cyc, input bit throttle, output int cyc, output int stall_lat);
    int wi, taken, st;
    wi = 0; taken = 0; st = 0; cyc = 0; stall_lat = -1;
    while (!cmd_ready && cyc < 2000) begin step(); cyc++; end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = LEN_W'(n);
    step();
    cmd_valid = 1'b0;
    cyc = 0;
    while (!done && cyc < 5000) begin
      if (wr) begin
        wr_valid = (wi < n) && (!throttle || $urandom_range(0, 2) != 0);
        wr_data  = (wi < n) ? wdat[wi] : 16'h0;
        if (wr_valid && wr_ready) wi++;
      end else begin
        if (taken == stall_word && rd_valid && st < stall_cyc) begin
          rd_ready = 1'b0;
          st++;
          if (st == stall_cyc) stall_lat = latch_q.size() - lb;
        end else begin
          rd_ready = !throttle || $urandom_range(0, 2) != 0;
        end
        if (rd_valid && rd_ready) taken++;
      end
      step();
      cyc++;
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
  endtask

  task automatic finish_burst(input string tag, input bit wr, input logic [22:0] a, input int n_lat,
                              input int n_rd, input bit exp_err);
    logic [22:0] ea;
    check({tag, "_done"}, done, 1);
    check({tag, "_err"}, err, exp_err);
    step();
    check({tag, "_idle"}, {done, busy}, 0);
    check({tag, "_donecnt"}, done_cnt - db, 1);
    check({tag, "_nlatch"}, latch_q.size() - lb, n_lat);
    for (int i = 0; i < n_lat; i++) begin
      ea = a + 23'(i);
      if (lb + i < latch_q.size()) begin
        check({tag, "_addr"}, latch_q[lb + i], ea);
        check({tag, "_instr"}, latch_w_q[lb + i], wr);
      end
    end
    check({tag, "_nread"}, rd_q.size() - rb, n_rd);
    for (int i = 0; i < n_rd; i++) begin
      ea = a + 23'(i);
      if (rb + i < rd_q.size()) check({tag, "_rdata"}, rd_q[rb + i], ref_rd(ea));
    end
  endtask

  initial begin
    int cyc, sl, k;
    logic [22:0] a;
    int n;

    repeat (3) step();
    check("rst_ctl", {cmd_ready, wr_ready, rd_valid, done, err, ram_latch, ram_instruction}, 0);
    check("rst_busy", busy, 1);
    check("rst_data", {ram_addr, ram_wdata, rd_data}, 0);
    rst = 1'b0;
    k = 0;
    while (!cmd_ready && k < 100) begin step(); k++; end
    check("recover_cyc", k, RECOVER_CYC);

    // Four-word read at full rate: 9 cycles per word.
    mark();
    run_burst(1'b0, 23'h000100, 4, -1, 0, 1'b0, cyc, sl);
    check("rd4_cycles", cyc, 36);
    finish_burst("rd4", 1'b0, 23'h000100, 4, 4, 1'b0);

    // Write across the top of the address space, then read it back.
    wdat = '{16'hAAAA, 16'h5555, 16'h1234};
    ref_write(23'h7FFFFE, 3);
    mark();
    run_burst(1'b1, 23'h7FFFFE, 3, -1, 0, 1'b0, cyc, sl);
    finish_burst("wr_wrap", 1'b1, 23'h7FFFFE, 3, 0, 1'b0);
    check("cmem_7ffffe", cmem_rd(23'h7FFFFE), 16'hAAAA);
    check("cmem_7fffff", cmem_rd(23'h7FFFFF), 16'h5555);
    check("cmem_000000", cmem_rd(23'h000000), 16'h1234);
    mark();
    run_burst(1'b0, 23'h7FFFFE, 3, -1, 0, 1'b0, cyc, sl);
    finish_burst("rb_wrap", 1'b0, 23'h7FFFFE, 3, 3, 1'b0);

    // Consumer stalls 20 cycles on the second word: the third access must wait.
    mark();
    run_burst(1'b0, 23'h000400, 3, 1, 20, 1'b0, cyc, sl);
    check("stall_latches", sl, 2);
    finish_burst("stall", 1'b0, 23'h000400, 3, 3, 1'b0);

    // Controller never answers: abort after TIMEOUT cycles in WAIT.
    hang = 1'b1;
    mark();
    run_burst(1'b0, 23'h000500, 2, -1, 0, 1'b0, cyc, sl);
    check("tmo_cycles", cyc, TIMEOUT + 2);
    finish_burst("tmo", 1'b0, 23'h000500, 1, 0, 1'b1);
    check("err_sticky", err, 1);
    hang = 1'b0;

    // Zero-length command: done in the cycle after the handshake cycle, no access, err cleared.
    mark();
    run_burst(1'b0, 23'h000600, 0, -1, 0, 1'b0, cyc, sl);
    check("len0_cycles", cyc, 0);
    finish_burst("len0", 1'b0, 23'h000600, 0, 0, 1'b0);

    // Reset while the second word of a read is in flight.
    mark();
    k = 0;
    while (!cmd_ready && k < 200) begin step(); k++; end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 23'h000200; cmd_len = LEN_W'(3); rd_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    k = 0;
    while (latch_q.size() - lb < 2 && k < 200) begin step(); k++; end
    check("mid_second_latch", latch_q.size() - lb, 2);
    step();
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_ctl", {cmd_ready, wr_ready, rd_valid, done, err, ram_latch, ram_instruction}, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_data", {ram_addr, ram_wdata, rd_data}, 0);
    step();
    step();
    rst = 1'b0;
    mark();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 23'h000300; cmd_len = LEN_W'(1);
    k = 0;
    while (!ram_latch && k < 100) begin
      step();
      k++;
      if (!cmd_ready && !busy) k = 1000;
    end
    check("post_rst_latch_gap", k >= RECOVER_CYC + 1 && k < 100, 1);
    cmd_valid = 1'b0;
    k = 0;
    while (!done && k < 200) begin step(); k++; end
    finish_burst("post_rst", 1'b0, 23'h000300, 1, 1, 1'b0);

    // Random write/read-back pairs with throttled streams.
    for (int r = 0; r < 4; r++) begin
      a = 23'($urandom);
      if (r == 0) a = 23'h7FFFFF - 23'($urandom_range(0, 2));
      n = $urandom_range(1, 5);
      wdat.delete();
      for (int i = 0; i < n; i++) wdat.push_back(16'($urandom));
      ref_write(a, n);
      mark();
      run_burst(1'b1, a, n, -1, 0, 1'b1, cyc, sl);
      finish_burst("rnd_wr", 1'b1, a, n, 0, 1'b0);
      mark();
      run_burst(1'b0, a, n, -1, 0, 1'b1, cyc, sl);
      finish_burst("rnd_rd", 1'b0, a, n, n, 1'b0);
    end

    check("latch_overlap", overlap_cnt, 0);
    check("req_stable", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
